ad5791_frame_serializer: RTL and testbench

- Generates the serial write frames for four AD5791 20-bit DACs and drives the shared PMD_clk/PMD_sync lines plus one PMD_dac data line per DAC; these outputs feed the expansion-connector IO stage directly.
- After reset it writes the AD5791 control register on all DACs once.
- It then accepts parallel DAC words over a valid/ready handshake and shifts them out simultaneously, MSB first.

---
 rtl/ad5791_frame_serializer.sv | 216 +++++++++++++++++++++
 tb/tb_ad5791_frame_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5791_frame_serializer.sv
// Serial write-frame generator for a bank of AD5791 20-bit DACs.
// All DACs share PMD_clk and PMD_sync, and each DAC has its own PMD_dac line.
// After reset the control register is written once. After that, parallel DAC
// words taken over a valid/ready handshake are shifted out MSB first on all
// lanes at the same time. A cfg_req pulse queues another control-register write.
//
// state | meaning
// ------+------------------------------------------------------------------
// INIT  | first cycle after reset; queues the control frame on every lane
// IDLE  | waiting; serves a pending control write first, then DAC data
// SHIFT | PMD_sync low; 24 bits, each CLK_DIV high then CLK_DIV low
// GAP   | PMD_sync high for SYNC_HIGH cycles before the next frame may start
module ad5791_frame_serializer #(
    parameter int                    NUM_DAC    = 4,
    parameter int                    DATA_WIDTH = 20,
    parameter int                    CLK_DIV    = 4,
    parameter int                    SYNC_HIGH  = 4,
    parameter logic [DATA_WIDTH-1:0] CTRL_INIT  = 20'h00022
) (
    input  logic                          a_clk,
    input  logic                          a_resetn,
    input  logic [NUM_DAC*DATA_WIDTH-1:0] dac_data,
    input  logic                          dac_valid,
    output logic                          dac_ready,
    input  logic                          cfg_req,
    output logic                          busy,
    output logic                          init_done,
    output logic                          PMD_clk,
    output logic                          PMD_sync,
    output logic [NUM_DAC-1:0]            PMD_dac
);

    localparam int FRAME_W = DATA_WIDTH + 4;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int HALF_W  = $clog2(CLK_DIV + 1);
    localparam int GAP_W   = $clog2(SYNC_HIGH + 1);

    localparam logic [BIT_W-1:0]   BIT_LOAD  = BIT_W'(FRAME_W - 1);
    localparam logic [HALF_W-1:0]  HALF_LOAD = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(SYNC_HIGH - 1);
    localparam logic [2:0]         ADDR_DAC  = 3'b001;
    localparam logic [2:0]         ADDR_CTRL = 3'b010;
    localparam logic [FRAME_W-1:0] CTRL_FRAME = {1'b0, ADDR_CTRL, CTRL_INIT};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // The bit currently on the wire is held in dac_q. The lane registers hold
    // only the bits that are still to be sent.
    logic [NUM_DAC-1:0][FRAME_W-2:0] lane_q, lane_d;
    logic [NUM_DAC-1:0][FRAME_W-1:0] load_frame;
    logic [BIT_W-1:0]                bit_q, bit_d;
    logic [HALF_W-1:0]               half_q, half_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            cfg_pend_q, cfg_pend_d;
    logic                            ready_q, ready_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            clk_q, clk_d;
    logic                            sync_q, sync_d;
    logic [NUM_DAC-1:0]              dac_q, dac_d;
    logic                            load_cfg;
    logic                            load_dat;
    logic                            cfg_in;

    // Frame each lane would load now: the control frame, or a DAC-register write of its slice.
    always_comb begin
        load_frame = '0;
        for (int k = 0; k < NUM_DAC; k++) begin
            if (load_cfg) begin
                load_frame[k] = CTRL_FRAME;
            end else begin
                load_frame[k] = {1'b0, ADDR_DAC, dac_data[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Next-state, counters, shift data and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        bit_d    = bit_q;
        half_d   = half_q;
        gap_d    = gap_q;
        busy_d   = busy_q;
        done_d   = done_q;
        clk_d    = clk_q;
        sync_d   = sync_q;
        dac_d    = dac_q;
        load_cfg = 1'b0;
        load_dat = 1'b0;
        // Requests made before the first control frame finishes are absorbed,
        // because that frame is already on its way.
        cfg_in   = cfg_req & done_q;

        case (state_q)
            ST_INIT: begin
                load_cfg = 1'b1;
            end
            ST_IDLE: begin
                if (cfg_pend_q) begin
                    load_cfg = 1'b1;
                end else if (dac_valid && ready_q) begin
                    load_dat = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (half_q != '0) begin
                    half_d = half_q - 1'b1;
                end else begin
                    half_d = HALF_LOAD;
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else if (bit_q == '0) begin
                        clk_d   = 1'b1;
                        sync_d  = 1'b1;
                        dac_d   = '0;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        // Data changes only while the clock goes back high, so it is
                        // stable across the falling edge where the DAC samples it.
                        clk_d = 1'b1;
                        bit_d = bit_q - 1'b1;
                        for (int k = 0; k < NUM_DAC; k++) begin
                            dac_d[k]  = lane_q[k][FRAME_W-2];
                            lane_d[k] = {lane_q[k][FRAME_W-3:0], 1'b0};
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (load_cfg || load_dat) begin
            for (int k = 0; k < NUM_DAC; k++) begin
                dac_d[k]  = load_frame[k][FRAME_W-1];
                lane_d[k] = load_frame[k][FRAME_W-2:0];
            end
            bit_d   = BIT_LOAD;
            half_d  = HALF_LOAD;
            clk_d   = 1'b1;
            sync_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
        end

        // A request that arrives in the same cycle the control frame is loaded
        // is merged into that frame.
        cfg_pend_d = load_cfg ? 1'b0 : (cfg_pend_q | cfg_in);
        ready_d    = (state_d == ST_IDLE) & done_d & ~cfg_pend_d;
    end

    // FSM state register.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and registered outputs. Reset raises sync right away, which aborts a write in flight.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            lane_q     <= '0;
            bit_q      <= '0;
            half_q     <= '0;
            gap_q      <= '0;
            cfg_pend_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clk_q      <= 1'b1;
            sync_q     <= 1'b1;
            dac_q      <= '0;
        end else begin
            lane_q     <= lane_d;
            bit_q      <= bit_d;
            half_q     <= half_d;
            gap_q      <= gap_d;
            cfg_pend_q <= cfg_pend_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clk_q      <= clk_d;
            sync_q     <= sync_d;
            dac_q      <= dac_d;
        end
    end

    assign dac_ready = ready_q;
    assign busy      = busy_q;
    assign init_done = done_q;
    assign PMD_clk   = clk_q;
    assign PMD_sync  = sync_q;
    assign PMD_dac   = dac_q;

endmodule

// File: tb/tb_ad5791_frame_serializer.sv
// Testbench for ad5791_frame_serializer. It has a frame-level reference model,
// a serial decoder and directed scenarios. A second instance with CLK_DIV=2
// is checked for clock timing and frame length.
module tb_ad5791_frame_serializer;

    localparam int CD        = 4;
    localparam int SH        = 4;
    localparam int FB        = 24;
    localparam int SHIFT_CYC = 2 * FB * CD;
    localparam int FRAME_CYC = SHIFT_CYC + SH;
    localparam logic [95:0] CTRL4 = {4{24'h200022}};

    logic        a_clk = 1'b0;
    logic        a_resetn = 1'b0;
    logic [79:0] dac_data = '0;
    logic        dac_valid = 1'b0;
    logic        cfg_req = 1'b0;
    logic        dac_ready, busy, init_done, PMD_clk, PMD_sync;
    logic [3:0]  PMD_dac;

    logic        rst2_n = 1'b0;
    logic [79:0] dac_data2 = '0;
    logic        dac_valid2 = 1'b0;
    logic        cfg_req2 = 1'b0;
    logic        ready2, busy2, done2, clk2, sync2;
    logic [3:0]  dac2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 a_clk = ~a_clk;

    ad5791_frame_serializer dut (
        .a_clk(a_clk), .a_resetn(a_resetn), .dac_data(dac_data), .dac_valid(dac_valid),
        .dac_ready(dac_ready), .cfg_req(cfg_req), .busy(busy), .init_done(init_done),
        .PMD_clk(PMD_clk), .PMD_sync(PMD_sync), .PMD_dac(PMD_dac)
    );

    ad5791_frame_serializer #(.CLK_DIV(2)) dut2 (
        .a_clk(a_clk), .a_resetn(rst2_n), .dac_data(dac_data2), .dac_valid(dac_valid2),
        .dac_ready(ready2), .cfg_req(cfg_req2), .busy(busy2), .init_done(done2),
        .PMD_clk(clk2), .PMD_sync(sync2), .PMD_dac(dac2)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for dac_ready", name);
    endtask

    function automatic logic [95:0] data_frames(input logic [79:0] d);
        logic [95:0] f;
        for (int k = 0; k < 4; k++) f[k*24 +: 24] = {4'b0001, d[k*20 +: 20]};
        return f;
    endfunction

    // ---------------- reference model (frame timeline) ----------------
    logic [23:0] m_word [4];
    int          m_off;
    bit          m_first, m_in_frame, m_idle, m_done, m_pend, m_ready;
    bit          m_req_in, m_load_c, m_load_d;

    always @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            m_first = 1; m_in_frame = 0; m_idle = 0; m_done = 0;
            m_pend = 0; m_ready = 0; m_off = 0;
        end else begin
            m_req_in = cfg_req && m_done;
            m_load_c = 0;
            m_load_d = 0;
            if (m_first) begin
                m_load_c = 1;
                m_first  = 0;
            end else if (m_in_frame) begin
                m_off++;
                if (m_off == FRAME_CYC) begin
                    m_in_frame = 0; m_idle = 1; m_done = 1;
                end
            end else if (m_idle) begin
                if (m_pend) begin
                    m_load_c = 1; m_pend = 0; m_req_in = 0;
                end else if (dac_valid && m_ready) begin
                    m_load_d = 1;
                end
            end
            if (m_load_c || m_load_d) begin
                m_in_frame = 1; m_idle = 0; m_off = 0;
                for (int k = 0; k < 4; k++)
                    m_word[k] = m_load_c ? 24'h200022 : {4'b0001, dac_data[k*20 +: 20]};
            end
            if (m_req_in) m_pend = 1;
            m_ready = m_idle && m_done && !m_pend;
        end
    end

    // Words the DUT accepted, recorded at the handshake edge.
    logic [79:0] acc_log [$];
    always @(posedge a_clk) begin
        if (a_resetn && dac_ready && dac_valid) acc_log.push_back(dac_data);
    end

    // ---------------- compare process + serial decoder ----------------
    logic [95:0] dec_log [$];
    logic [23:0] dword [4];
    int  cyc = 0, nbits = 0, last_rise = -1, fall_cyc = 0, aborted = 0;
    bit  p_sync = 1, p_clk = 1, p_done = 0;
    logic e_clk, e_sync;
    logic [3:0] e_dac;

    always @(posedge a_clk) begin
        #3;
        cyc++;
        if (m_in_frame && m_off < SHIFT_CYC) begin
            e_sync = 1'b0;
            e_clk  = ((m_off % (2 * CD)) < CD);
            for (int k = 0; k < 4; k++) e_dac[k] = m_word[k][FB - 1 - m_off / (2 * CD)];
        end else begin
            e_sync = 1'b1; e_clk = 1'b1; e_dac = '0;
        end
        check("outputs_vs_model",
              {busy, dac_ready, init_done, PMD_clk, PMD_sync, PMD_dac},
              {m_in_frame, m_ready, m_done, e_clk, e_sync, e_dac});

        if (!a_resetn) begin
            if (nbits != 0) aborted++;
            nbits = 0; last_rise = -1; p_sync = 1; p_clk = 1; p_done = 0;
        end else begin
            if (p_sync && !PMD_sync) begin
                if (last_rise >= 0) check("sync_gap_min", (cyc - last_rise) >= SH, 1'b1);
                nbits = 0;
                fall_cyc = cyc;
            end
            if (!PMD_sync && p_clk && !PMD_clk) begin
                for (int k = 0; k < 4; k++) dword[k] = {dword[k][22:0], PMD_dac[k]};
                nbits++;
            end
            if (!p_sync && PMD_sync) begin
                check("falling_edges_per_frame", nbits, FB);
                dec_log.push_back({dword[3], dword[2], dword[1], dword[0]});
                nbits = 0;
                last_rise = cyc;
            end
            if (!p_done && init_done) check("init_done_latency", cyc - fall_cyc, FRAME_CYC);
            p_sync = PMD_sync; p_clk = PMD_clk; p_done = init_done;
        end
    end

    // ---------------- CLK_DIV=2 instance monitor ----------------
    logic [23:0] w2 [4];
    int  cyc2 = 0, fall2 = 0, rise2 = -1, nb2 = 0;
    bit  p2_sync = 1, p2_clk = 1, p2_done = 0;
    logic [3:0] p2_dac = '0;

    always @(posedge a_clk) begin
        #3;
        cyc2++;
        if (rst2_n) begin
            if (p2_sync && !sync2) begin
                fall2 = cyc2; nb2 = 0; rise2 = -1;
            end
            if (!sync2 && !p2_clk && clk2) begin
                if (rise2 >= 0) check("clkdiv2_period", cyc2 - rise2, 4);
                rise2 = cyc2;
            end
            if (!sync2 && !p2_sync && dac2 != p2_dac) check("clkdiv2_dac_on_rise", {p2_clk, clk2}, 2'b01);
            if (!sync2 && p2_clk && !clk2) begin
                for (int k = 0; k < 4; k++) w2[k] = {w2[k][22:0], dac2[k]};
                nb2++;
            end
            if (!p2_sync && sync2) begin
                check("clkdiv2_bits", nb2, FB);
                check("clkdiv2_init_frame", {w2[3], w2[2], w2[1], w2[0]}, CTRL4);
            end
            if (!p2_done && done2) check("clkdiv2_frame_cost", cyc2 - fall2, 100);
        end
        p2_sync = sync2; p2_clk = clk2; p2_done = done2; p2_dac = dac2;
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready(input string name);
        int n = 0;
        while (!dac_ready && n < 3000) begin
            @(negedge a_clk);
            n++;
        end
        if (!dac_ready) timeout_fail(name);
    endtask

    initial begin
        int n, base, ab0;
        logic [95:0] rnd;
        logic [79:0] d1, d2, d3;

        repeat (3) @(negedge a_clk);
        check("reset_outputs", {PMD_clk, PMD_sync, PMD_dac, dac_ready, busy, init_done}, 9'b1_1_0000_000);
        a_resetn = 1'b1;
        rst2_n   = 1'b1;

        // Init frame.
        wait_ready("init");
        check("init_frame_count", dec_log.size(), 1);
        if (dec_log.size() >= 1) check("init_frame_value", dec_log[0], CTRL4);

        // Single data frame with boundary codes.
        dac_data  = {20'h12345, 20'hFFFFF, 20'h00001, 20'h80000};
        dac_valid = 1'b1;
        @(negedge a_clk);
        dac_valid = 1'b0;
        dac_data  = '1;
        n = 0;
        while (!dac_ready && n < 1000) begin
            n++;
            @(negedge a_clk);
        end
        check("ready_low_cycles", n, FRAME_CYC);
        check("data_frame_value", dec_log[dec_log.size()-1],
              {24'h112345, 24'h1FFFFF, 24'h100001, 24'h180000});

        // Valid held high with data changing every cycle.
        acc_log.delete();
        base = dec_log.size();
        dac_valid = 1'b1;
        n = 0;
        while (acc_log.size() < 3 && n < 2000) begin
            rnd = {$urandom, $urandom, $urandom};
            dac_data = rnd[79:0];
            @(negedge a_clk);
            n++;
        end
        dac_valid = 1'b0;
        wait_ready("stream");
        check("stream_accept_count", acc_log.size(), 3);
        check("stream_frame_count", dec_log.size() - base, 3);
        if (acc_log.size() >= 3 && dec_log.size() >= base + 3)
            for (int i = 0; i < 3; i++) check("stream_word", dec_log[base + i], data_frames(acc_log[i]));

        // Two cfg_req pulses during a frame while data is waiting.
        base = dec_log.size();
        d1 = {20'h44444, 20'h33333, 20'h22222, 20'h11111};
        d2 = {20'h0CAFE, 20'hBEEF0, 20'h55555, 20'hAAAAA};
        dac_data  = d1;
        dac_valid = 1'b1;
        @(negedge a_clk);
        dac_data = d2;
        repeat (30) @(negedge a_clk);
        cfg_req = 1'b1;
        @(negedge a_clk);
        cfg_req = 1'b0;
        repeat (20) @(negedge a_clk);
        cfg_req = 1'b1;
        @(negedge a_clk);
        cfg_req = 1'b0;
        wait_ready("cfg_then_data");
        @(negedge a_clk);
        dac_valid = 1'b0;
        wait_ready("cfg_end");
        check("cfg_frame_count", dec_log.size() - base, 3);
        if (dec_log.size() >= base + 3) begin
            check("cfg_seq_data1", dec_log[base],     {24'h144444, 24'h133333, 24'h122222, 24'h111111});
            check("cfg_seq_ctrl",  dec_log[base + 1], CTRL4);
            check("cfg_seq_data2", dec_log[base + 2], {24'h10CAFE, 24'h1BEEF0, 24'h155555, 24'h1AAAAA});
        end

        // Reset asserted during bit 10 of a data frame.
        base = dec_log.size();
        ab0  = aborted;
        d3 = {20'h13579, 20'h2468A, 20'hFEDCB, 20'h00000};
        dac_data  = d3;
        dac_valid = 1'b1;
        @(negedge a_clk);
        repeat (105) @(negedge a_clk);
        check("bit10_sync_low", PMD_sync, 1'b0);
        a_resetn = 1'b0;
        #1;
        check("reset_midframe", {PMD_clk, PMD_sync, PMD_dac, dac_ready, busy, init_done}, 9'b1_1_0000_000);
        repeat (3) @(negedge a_clk);
        a_resetn = 1'b1;
        wait_ready("post_reset");
        @(negedge a_clk);
        dac_valid = 1'b0;
        wait_ready("post_reset_end");
        check("aborted_frames", aborted - ab0, 1);
        check("post_reset_frame_count", dec_log.size() - base, 2);
        if (dec_log.size() >= base + 2) begin
            check("post_reset_ctrl", dec_log[base], CTRL4);
            check("post_reset_data", dec_log[base + 1], {24'h113579, 24'h12468A, 24'h1FEDCB, 24'h100000});
        end
        check("clkdiv2_init_done", done2, 1'b1);

        repeat (5) @(negedge a_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
